// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared operation encodings for the bit-slice ALU.
//   No ports; imported by the slice and the registered top.
package alu_pkg;
   localparam logic [2:0] OP_PASSB = 3'b000;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_AND   = 3'b100;
   localparam logic [2:0] OP_OR    = 3'b101;
   localparam logic [2:0] OP_XOR   = 3'b110;

   // 001 and 111 leave every registered output untouched.
   function automatic logic is_reserved(input logic [2:0] op);
      return (op == 3'b001) || (op == 3'b111);
   endfunction
endpackage

// File: rtl/adder.sv
// adder
//   One-bit full adder leaf cell.
//   Ports: A, B, cin -> sum, cout (majority carry).
module adder (
   input  logic A,
   input  logic B,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = A ^ B ^ cin;
   assign cout = (A & B) | (A & cin) | (B & cin);
endmodule

// File: rtl/alu_bit_slice.sv
// alu_bit_slice
//   One bit of the ALU: optional B inversion, full add, logic ops and the
//   final operation select.
//   Ports: cntrl[2:0] op select, A/B operand bits, cin carry in,
//          hold current registered result bit (chosen for reserved ops),
//          cout carry out, result next result bit.
import alu_pkg::*;

module alu_bit_slice (
   input  logic [2:0] cntrl,
   input  logic       A,
   input  logic       B,
   input  logic       cin,
   input  logic       hold,
   output logic       cout,
   output logic       result
);
   logic b_mod;
   logic sum;
   logic and_bit;
   logic or_bit;
   logic xor_bit;

   // cntrl[0] inverts B so that 011 computes A + ~B + 1 with the LSB carry.
   mux2_1 u_binv (
      .sel (cntrl[0]),
      .i0  (B),
      .i1  (~B),
      .out (b_mod)
   );

   adder u_add (
      .A    (A),
      .B    (b_mod),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
   );

   assign and_bit = A & B;
   assign or_bit  = A | B;
   assign xor_bit = A ^ B;

   mux8_1 u_sel (
      .sel ({cntrl[2], cntrl[1], cntrl[0]}),
      .i   ({hold, xor_bit, or_bit, and_bit, sum, sum, hold, B}),
      .out (result)
   );
endmodule

// File: rtl/mux2_1.sv
// mux2_1
//   Two-input multiplexer leaf cell.
//   Ports: sel, i0, i1 -> out (i1 when sel is high).
module mux2_1 (
   input  logic sel,
   input  logic i0,
   input  logic i1,
   output logic out
);
   assign out = sel ? i1 : i0;
endmodule

// File: rtl/mux8_1.sv
// mux8_1
//   Eight-input multiplexer leaf cell.
//   Ports: sel[2:0] = {sel2,sel1,sel0}, i[7:0] -> out = i[sel].
module mux8_1 (
   input  logic [2:0] sel,
   input  logic [7:0] i,
   output logic       out
);
   assign out = i[sel];
endmodule

// File: rtl/alu_bit_slice_reg.sv
// alu_bit_slice_reg
//   WIDTH-bit ripple ALU built from alu_bit_slice, with registered result
//   and flags (one-cycle latency).
//   Ports: clk, reset (async, active-high), cntrl[2:0], A, B,
//          result, cout, overflow, zero, negative.
import alu_pkg::*;

module alu_bit_slice_reg #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       cntrl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] result_d;
   logic             arith;
   logic             reserved;

   assign carry[0] = cntrl[0];
   assign arith    = (cntrl == OP_ADD) || (cntrl == OP_SUB);
   assign reserved = is_reserved(cntrl);

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_slice
         alu_bit_slice u_slice (
            .cntrl  (cntrl),
            .A      (A[i]),
            .B      (B[i]),
            .cin    (carry[i]),
            .hold   (result[i]),
            .cout   (carry[i+1]),
            .result (result_d[i])
         );
      end
   endgenerate

   // Result always reloads (the slices feed back the held bit for reserved
   // ops); flags are frozen explicitly so zero stays 0 right after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         negative <= 1'b0;
      end else begin
         result <= result_d;
         if (!reserved) begin
            cout     <= arith & carry[WIDTH];
            overflow <= arith & (carry[WIDTH] ^ carry[WIDTH-1]);
            zero     <= (result_d == '0);
            negative <= result_d[WIDTH-1];
         end
      end
   end
endmodule

// File: tb/tb_alu_bit_slice_reg.sv
// Testbench for alu_bit_slice_reg at WIDTH=64: directed table, reset and
// hold sequences, exhaustive 2-bit sweep and random ops against a model.
import alu_pkg::*;

module tb_alu_bit_slice_reg;
   localparam int W = 64;

   logic         clk;
   logic         reset;
   logic [2:0]   cntrl;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;
   logic         zero;
   logic         negative;

   int errors = 0;
   int checks = 0;

   // model state
   logic [W-1:0] m_res;
   logic         m_cout, m_ovf, m_zero, m_neg;

   typedef struct {
      string        name;
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         c;
      logic         o;
      logic         z;
      logic         n;
   } vec_t;

   vec_t vecs[10];

   alu_bit_slice_reg #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .cntrl    (cntrl),
      .A        (A),
      .B        (B),
      .result   (result),
      .cout     (cout),
      .overflow (overflow),
      .zero     (zero),
      .negative (negative)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_res = '0; m_cout = 0; m_ovf = 0; m_zero = 0; m_neg = 0;
   endtask

   // Arithmetic model using wide integer math and operand signs.
   task automatic model_step(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0]   s;
      logic [W-1:0] r;
      logic         c, o;
      c = 0; o = 0; r = m_res;
      case (op)
         OP_PASSB: r = b;
         OP_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0]; c = s[W];
            o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         OP_SUB: begin
            s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
            r = s[W-1:0]; c = s[W];
            o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         default: return;
      endcase
      m_res = r; m_cout = c; m_ovf = o; m_zero = (r == '0); m_neg = r[W-1];
   endtask

   task automatic check_all(input string name, input logic [W-1:0] r, input logic c,
                            input logic o, input logic z, input logic n);
      checks++;
      if (result !== r || cout !== c || overflow !== o || zero !== z || negative !== n) begin
         errors++;
         $display("FAIL %s: got res=%h c=%b o=%b z=%b n=%b, want res=%h c=%b o=%b z=%b n=%b",
                  name, result, cout, overflow, zero, negative, r, c, o, z, n);
      end
   endtask

   task automatic check_model(input string name);
      check_all(name, m_res, m_cout, m_ovf, m_zero, m_neg);
   endtask

   // Called one time unit after a rising edge; applies op, waits one edge.
   task automatic step(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      cntrl = op; A = a; B = b;
      @(posedge clk);
      #1;
      model_step(op, a, b);
   endtask

   initial begin
      vecs[0] = '{"sub_3_5",   OP_SUB,   64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1};
      vecs[1] = '{"sub_5_5",   OP_SUB,   64'd5, 64'd5, 64'h0, 1, 0, 1, 0};
      vecs[2] = '{"add_ovf",   OP_ADD,   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 0, 1, 0, 1};
      vecs[3] = '{"add_wrap",  OP_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1, 0, 1, 0};
      vecs[4] = '{"and_c_a",   OP_AND,   64'hC, 64'hA, 64'h8, 0, 0, 0, 0};
      vecs[5] = '{"or_c_a",    OP_OR,    64'hC, 64'hA, 64'hE, 0, 0, 0, 0};
      vecs[6] = '{"xor_c_a",   OP_XOR,   64'hC, 64'hA, 64'h6, 0, 0, 0, 0};
      vecs[7] = '{"passb_c_a", OP_PASSB, 64'hC, 64'hA, 64'hA, 0, 0, 0, 0};
      vecs[8] = '{"sub_ovf",   OP_SUB,   64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 0};
      vecs[9] = '{"add_neg",   OP_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 1};

      reset = 1; cntrl = OP_ADD; A = 64'd5; B = 64'd3;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset_init", '0, 0, 0, 0, 0);

      // reserved op right after reset holds all zeros, including zero=0
      reset = 0;
      step(3'b001, 64'd7, 64'd7);
      check_all("reserved_after_reset", '0, 0, 0, 0, 0);

      step(OP_ADD, 64'd5, 64'd3);
      check_all("add_5_3", 64'd8, 0, 0, 0, 0);

      // async reset mid-cycle: no clock edge in between
      reset = 1;
      #1;
      model_reset();
      check_all("async_reset", '0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_all("reset_held", '0, 0, 0, 0, 0);
      reset = 0;
      step(OP_ADD, 64'd5, 64'd3);
      check_all("add_after_reset", 64'd8, 0, 0, 0, 0);

      for (int i = 0; i < 10; i++) begin
         step(vecs[i].op, vecs[i].a, vecs[i].b);
         check_all(vecs[i].name, vecs[i].res, vecs[i].c, vecs[i].o, vecs[i].z, vecs[i].n);
      end

      // hold: reserved ops keep result 8 and the flags from the ADD
      step(OP_ADD, 64'd5, 64'd3);
      for (int i = 0; i < 3; i++) begin
         step(3'b001, 64'hFF, 64'hFF);
         check_all("hold_001", 64'd8, 0, 0, 0, 0);
      end
      for (int i = 0; i < 3; i++) begin
         step(3'b111, 64'hFF, 64'hFF);
         check_all("hold_111", 64'd8, 0, 0, 0, 0);
      end
      // hold after a flag-setting op keeps the set flags
      step(OP_SUB, 64'd5, 64'd5);
      step(3'b111, 64'd1, 64'd2);
      check_all("hold_flags", '0, 1, 0, 1, 0);

      // exhaustive 2-bit sweep
      for (int op = 0; op < 8; op++)
         for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
               step(3'(op), 64'(a), 64'(b));
               check_model("sweep");
            end

      // random ops including reserved, full-width operands
      for (int i = 0; i < 400; i++) begin
         logic [W-1:0] ra, rb;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (i % 7 == 0) rb = ra;
         step(3'($urandom_range(0, 7)), ra, rb);
         check_model("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
